// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner for NUM_DIGITS common-anode digits.
// Double-buffered display data (pending/active), per-digit raw patterns,
// leading-zero suppression, per-digit blink and anti-ghost blanking at the
// start of every digit slot. All pin outputs are registered.
module seg_scan_mux #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned BLINK_CYCLES   = 50000000
) (
  input  logic                    clk_100MHz,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   raw_mode,
  input  logic [7*NUM_DIGITS-1:0] raw_seg,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  input  logic                    lz_suppress,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    frame_done
);

  localparam int unsigned SelW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SlotW  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [SelW-1:0]   SelLast   = SelW'(NUM_DIGITS - 1);
  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_CYCLES - 1);
  localparam logic [SlotW-1:0]  SlotBlank = SlotW'(BLANK_CYCLES);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  // Internal patterns use [6]=a .. [0]=g; seg[0:6] maps [6] onto seg[0].
  localparam logic [6:0] PatOff  = 7'b1111111;
  localparam logic [6:0] PatDash = 7'b1111110;

  // Scan and blink timing state
  logic [SlotW-1:0]  slot_cnt_q, slot_cnt_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic              slot_end;
  logic              wrap;
  logic              blink_end;

  // Pending buffer (written by load)
  logic [4*NUM_DIGITS-1:0] pend_data_q;
  logic [NUM_DIGITS-1:0]   pend_raw_mode_q;
  logic [7*NUM_DIGITS-1:0] pend_raw_seg_q;
  logic [NUM_DIGITS-1:0]   pend_blink_q;
  logic                    pend_lz_q;

  // Active buffer (what the scan displays)
  logic [4*NUM_DIGITS-1:0] act_data_q;
  logic [NUM_DIGITS-1:0]   act_raw_mode_q;
  logic [7*NUM_DIGITS-1:0] act_raw_seg_q;
  logic [NUM_DIGITS-1:0]   act_blink_q;
  logic                    act_lz_q;

  // Per-digit display patterns and output selection
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  lz_run;
  logic [6:0]            digit_pat [NUM_DIGITS];
  logic [6:0]            cur_pat;
  logic                  in_blank;
  logic [NUM_DIGITS-1:0] digit_sel;

  // Registered pin drivers
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] digit_q;
  logic                  frame_done_q;

  // BCD to active-low segments; non-decimal codes show a dash
  function automatic logic [6:0] decode_bcd(input logic [3:0] val);
    logic [6:0] pat;
    case (val)
      4'd0:    pat = 7'b0000001;
      4'd1:    pat = 7'b1001111;
      4'd2:    pat = 7'b0010010;
      4'd3:    pat = 7'b0000110;
      4'd4:    pat = 7'b1001100;
      4'd5:    pat = 7'b0100100;
      4'd6:    pat = 7'b0100000;
      4'd7:    pat = 7'b0001111;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0000100;
      default: pat = PatDash;
    endcase
    return pat;
  endfunction

  // Slot timer, digit select and blink timer next-state
  always_comb begin
    slot_end      = (slot_cnt_q == SlotLast);
    wrap          = slot_end && (sel_q == SelLast);
    blink_end     = (blink_cnt_q == BlinkLast);
    slot_cnt_d    = slot_end ? '0 : slot_cnt_q + SlotW'(1);
    sel_d         = sel_q;
    if (slot_end) begin
      sel_d = wrap ? '0 : sel_q + SelW'(1);
    end
    blink_cnt_d   = blink_end ? '0 : blink_cnt_q + BlinkW'(1);
    blink_phase_d = blink_end ? ~blink_phase_q : blink_phase_q;
  end

  // Timing state registers
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q    <= '0;
      sel_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Pending buffer: last load in a frame wins
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      pend_data_q     <= '0;
      pend_raw_mode_q <= '0;
      pend_raw_seg_q  <= '0;
      pend_blink_q    <= '0;
      pend_lz_q       <= 1'b0;
    end else if (load) begin
      pend_data_q     <= digit_data;
      pend_raw_mode_q <= raw_mode;
      pend_raw_seg_q  <= raw_seg;
      pend_blink_q    <= blink_en;
      pend_lz_q       <= lz_suppress;
    end
  end

  // Active buffer: commits only on the frame wrap, so a load on that same
  // edge lands in pending and waits for the following wrap.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      act_data_q     <= '0;
      act_raw_mode_q <= '0;
      act_raw_seg_q  <= '0;
      act_blink_q    <= '0;
      act_lz_q       <= 1'b0;
    end else if (wrap) begin
      act_data_q     <= pend_data_q;
      act_raw_mode_q <= pend_raw_mode_q;
      act_raw_seg_q  <= pend_raw_seg_q;
      act_blink_q    <= pend_blink_q;
      act_lz_q       <= pend_lz_q;
    end
  end

  // Leading-zero chain from the most significant digit down; a raw-mode or
  // nonzero digit ends the run, and digit 0 is never part of it.
  always_comb begin
    lz_blank = '0;
    lz_run   = act_lz_q;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (lz_run && !act_raw_mode_q[i] && (act_data_q[4*i +: 4] == 4'd0)) begin
        lz_blank[i] = 1'b1;
      end else begin
        lz_run = 1'b0;
      end
    end
  end

  // Per-digit pattern: raw or decoded, then suppression and blink blanking
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (act_raw_mode_q[i]) begin
        digit_pat[i] = act_raw_seg_q[7*i +: 7];
      end else begin
        digit_pat[i] = decode_bcd(act_data_q[4*i +: 4]);
      end
      if (lz_blank[i] || (blink_phase_q && act_blink_q[i])) begin
        digit_pat[i] = PatOff;
      end
    end
  end

  // Output selection for the current slot
  always_comb begin
    cur_pat   = digit_pat[sel_q];
    in_blank  = (BLANK_CYCLES != 0) && (slot_cnt_q < SlotBlank);
    digit_sel = ~(NUM_DIGITS'(1) << sel_q);
  end

  // Pin registers; reset turns every digit and segment off immediately
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= PatOff;
      digit_q      <= '1;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= cur_pat;
      digit_q      <= in_blank ? '1 : digit_sel;
      frame_done_q <= wrap;
    end
  end

  assign seg        = seg_q;
  assign digit      = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: table of load vectors with hand-decoded
// expected segments, plus sequences for reset, buffering, blink and N=3 wrap.
module tb_seg_scan_mux;

  localparam logic [6:0] P0 = 7'b0000001;
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] P5 = 7'b0100100;
  localparam logic [6:0] P6 = 7'b0100000;
  localparam logic [6:0] P7 = 7'b0001111;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] P9 = 7'b0000100;
  localparam logic [6:0] PB = 7'b1111111;
  localparam logic [6:0] PD = 7'b1111110;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  raw_mode;
    logic [27:0] raw_seg;
    logic        lz;
    logic [27:0] exp;  // {digit3, digit2, digit1, digit0}, each [6]=a
  } vec_t;

  logic        clk_100MHz;
  logic        rst_n;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  raw_mode;
  logic [27:0] raw_seg;
  logic [3:0]  blink_en;
  logic        lz_suppress;
  logic [0:6]  seg;
  logic [3:0]  digit;
  logic        frame_done;

  logic [0:6]  seg3;
  logic [2:0]  digit3;
  logic        frame_done3;

  logic [6:0]  seg_v;
  int          errors;
  int          checks;
  int          cyc;
  vec_t        vecs [9];

  assign seg_v = seg;

  seg_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(10), .BLANK_CYCLES(2), .BLINK_CYCLES(100)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .load       (load),
    .digit_data (digit_data),
    .raw_mode   (raw_mode),
    .raw_seg    (raw_seg),
    .blink_en   (blink_en),
    .lz_suppress(lz_suppress),
    .seg        (seg),
    .digit      (digit),
    .frame_done (frame_done)
  );

  seg_scan_mux #(
    .NUM_DIGITS(3), .REFRESH_CYCLES(10), .BLANK_CYCLES(2), .BLINK_CYCLES(100)
  ) dut3 (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .load       (1'b0),
    .digit_data (12'h000),
    .raw_mode   (3'b000),
    .raw_seg    (21'h0),
    .blink_en   (3'b000),
    .lz_suppress(1'b0),
    .seg        (seg3),
    .digit      (digit3),
    .frame_done (frame_done3)
  );

  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  // Posedges since the last reset release; used to predict blink phase
  always @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic wait_fd(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done && n < 200);
    if (!frame_done) chk({nm, "_fd_timeout"}, 32'(frame_done), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] rm, input logic [27:0] rs,
                         input logic [3:0] bl, input logic lz);
    digit_data  = d;
    raw_mode    = rm;
    raw_seg     = rs;
    blink_en    = bl;
    lz_suppress = lz;
    load        = 1'b1;
    @(negedge clk_100MHz);
    load        = 1'b0;
  endtask

  task automatic find_digit(input logic [3:0] tgt);
    int n;
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (digit !== tgt && n < 60);
  endtask

  // Checks digits first..3 of the frame in progress
  task automatic check_digits(input logic [27:0] exp, input int first, input string nm);
    logic [3:0] tgt;
    for (int i = first; i < 4; i++) begin
      tgt = ~(4'b0001 << i);
      find_digit(tgt);
      chk($sformatf("%s_en%0d", nm, i), 32'(digit), 32'(tgt));
      chk($sformatf("%s_seg%0d", nm, i), 32'(seg_v), 32'(exp[7*i +: 7]));
    end
  endtask

  initial begin
    int          n;
    logic [3:0]  tgt;
    logic [2:0]  tgt3;
    logic [27:0] old_exp;
    logic [6:0]  bexp;

    errors = 0;
    checks = 0;
    vecs[0] = '{data: 16'h0042, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b1,
                exp: {PB, PB, P4, P2}};
    vecs[1] = '{data: 16'h0A00, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b0,
                exp: {P0, PD, P0, P0}};
    vecs[2] = '{data: 16'h0000, raw_mode: 4'b1000, raw_seg: {7'b0001000, 7'h55, 7'h55, 7'h55},
                lz: 1'b1, exp: {7'b0001000, P0, P0, P0}};
    vecs[3] = '{data: 16'h1234, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b0,
                exp: {P1, P2, P3, P4}};
    vecs[4] = '{data: 16'h5678, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b0,
                exp: {P5, P6, P7, P8}};
    vecs[5] = '{data: 16'h9000, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b1,
                exp: {P9, P0, P0, P0}};
    vecs[6] = '{data: 16'h0000, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b1,
                exp: {PB, PB, PB, P0}};
    vecs[7] = '{data: 16'h0F03, raw_mode: 4'h0, raw_seg: 28'h0, lz: 1'b1,
                exp: {PB, PD, P0, P3}};
    vecs[8] = '{data: 16'h0000, raw_mode: 4'b0001, raw_seg: {7'h55, 7'h55, 7'h55, 7'b1110000},
                lz: 1'b1, exp: {PB, PB, PB, 7'b1110000}};

    rst_n = 1'b0;
    load = 1'b0;
    digit_data = '0;
    raw_mode = '0;
    raw_seg = '0;
    blink_en = '0;
    lz_suppress = 1'b0;
    repeat (3) @(negedge clk_100MHz);
    chk("rst_seg", 32'(seg_v), 32'(PB));
    chk("rst_digit", 32'(digit), 32'hF);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;

    // Reset mid-slot with a pending load that must be discarded
    do_load(16'h1234, 4'h0, 28'h0, 4'h0, 1'b0);
    repeat (4) @(negedge clk_100MHz);
    chk("pre_rst_digit", 32'(digit), 32'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg_v), 32'(PB));
    chk("async_rst_digit", 32'(digit), 32'hF);
    chk("async_rst_fd", 32'(frame_done), 32'd0);
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    @(negedge clk_100MHz);
    chk("blank_c1", 32'(digit), 32'hF);
    @(negedge clk_100MHz);
    chk("blank_c2", 32'(digit), 32'hF);
    @(negedge clk_100MHz);
    chk("first_digit", 32'(digit), 32'hE);
    chk("first_seg", 32'(seg_v), 32'(P0));
    n = 3;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done && n < 100);
    chk("first_fd_cycle", 32'(n), 32'd40);
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done && n < 100);
    chk("fd_period", 32'(n), 32'd40);
    check_digits({P0, P0, P0, P0}, 0, "pend_lost");

    // Table-driven decode / suppression / raw vectors
    for (int v = 0; v < 9; v++) begin
      wait_fd($sformatf("vec%0d_a", v));
      do_load(vecs[v].data, vecs[v].raw_mode, vecs[v].raw_seg, 4'h0, vecs[v].lz);
      wait_fd($sformatf("vec%0d_b", v));
      check_digits(vecs[v].exp, 0, $sformatf("vec%0d", v));
    end

    // Two loads in one frame: display holds old data, then last load wins
    old_exp = vecs[8].exp;
    wait_fd("dbl_a");
    do_load(16'h1234, 4'h0, 28'h0, 4'h0, 1'b0);
    repeat (8) @(negedge clk_100MHz);
    do_load(16'h5678, 4'h0, 28'h0, 4'h0, 1'b0);
    check_digits(old_exp, 2, "dbl_old");
    wait_fd("dbl_b");
    check_digits(vecs[4].exp, 0, "dbl_new");

    // Load coincident with the wrap edge is deferred by one frame
    wait_fd("wrap_a");
    repeat (39) @(negedge clk_100MHz);
    digit_data = 16'h9999;
    load = 1'b1;
    @(negedge clk_100MHz);
    load = 1'b0;
    chk("wrap_edge_fd", 32'(frame_done), 32'd1);
    check_digits(vecs[4].exp, 0, "wrap_defer");
    wait_fd("wrap_b");
    check_digits({P9, P9, P9, P9}, 0, "wrap_commit");

    // Blink on digit 1 only; phase predicted from posedge count
    wait_fd("blink_a");
    do_load(16'h0042, 4'h0, 28'h0, 4'b0010, 1'b0);
    wait_fd("blink_b");
    for (int f = 0; f < 8; f++) begin
      tgt = 4'b1110;
      find_digit(tgt);
      chk($sformatf("blink_f%0d_d0", f), 32'(seg_v), 32'(P2));
      tgt = 4'b1101;
      find_digit(tgt);
      chk($sformatf("blink_f%0d_en1", f), 32'(digit), 32'(tgt));
      bexp = (((cyc - 1) / 100) % 2 == 1) ? PB : P4;
      chk($sformatf("blink_f%0d_d1", f), 32'(seg_v), 32'(bexp));
      wait_fd($sformatf("blink_f%0d", f));
    end

    // Three-digit instance: wraps 2 -> 0 with a 30-cycle frame
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done3 && n < 100);
    chk("n3_fd_seen", 32'(frame_done3), 32'd1);
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while (!frame_done3 && n < 100);
    chk("n3_fd_period", 32'(n), 32'd30);
    for (int i = 0; i < 3; i++) begin
      tgt3 = ~(3'b001 << i);
      n = 0;
      do begin
        @(negedge clk_100MHz);
        n++;
      end while (digit3 !== tgt3 && n < 40);
      chk($sformatf("n3_en%0d", i), 32'(digit3), 32'(tgt3));
    end
    n = 0;
    do begin
      @(negedge clk_100MHz);
      n++;
    end while ((digit3 === 3'b011 || digit3 === 3'b111) && n < 40);
    chk("n3_wrap_to0", 32'(digit3), 32'(3'b110));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
